// File: rtl/serial_sub_pkg.sv
// Shared constants for the bit-serial subtract/negate engine.
package serial_sub_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  localparam logic OP_SUB = 1'b0;
  localparam logic OP_NEG = 1'b1;

  // Bit-counter width; a 2-bit operand still needs a 1-bit counter.
  function automatic int cnt_width(input int width);
    return (width > 2) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/full_sub.sv
// One-bit full subtractor: x - y - bin, producing difference and borrow.
module full_sub
  import serial_sub_pkg::*;
(
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = x ^ y ^ bin;
  assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/serial_sub_ctrl.sv
// Bit-serial A-B / 0-B engine: one full-subtractor cell stepped LSB first
// over WIDTH cycles, with a start/busy/done handshake.
module serial_sub_ctrl
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             ovf
);

  localparam int CNT_W = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [1:0]       state_r;
  logic [WIDTH-1:0] sa_r;
  logic [WIDTH-1:0] sb_r;
  logic [WIDTH-1:0] sr_r;
  logic             bor_r;
  logic             a_msb_r;
  logic             b_msb_r;
  logic [CNT_W-1:0] cnt_r;
  logic [WIDTH-1:0] diff_r;
  logic             borrow_r;
  logic             ovf_r;
  logic             busy_r;
  logic             done_r;

  logic             d_s;
  logic             bo_s;
  logic [WIDTH-1:0] sr_next_s;

  full_sub u_cell (
    .x    (sa_r[0]),
    .y    (sb_r[0]),
    .bin  (bor_r),
    .d    (d_s),
    .bout (bo_s)
  );

  assign sr_next_s = {d_s, sr_r[WIDTH-1:1]};

  // FSM, operand/result shifters and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r  <= ST_IDLE;
      sa_r     <= {WIDTH{1'b0}};
      sb_r     <= {WIDTH{1'b0}};
      sr_r     <= {WIDTH{1'b0}};
      bor_r    <= 1'b0;
      a_msb_r  <= 1'b0;
      b_msb_r  <= 1'b0;
      cnt_r    <= {CNT_W{1'b0}};
      diff_r   <= {WIDTH{1'b0}};
      borrow_r <= 1'b0;
      ovf_r    <= 1'b0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          done_r <= 1'b0;
          if (start) begin
            sa_r    <= (op == OP_NEG) ? {WIDTH{1'b0}} : a;
            sb_r    <= b;
            a_msb_r <= (op == OP_NEG) ? 1'b0 : a[WIDTH-1];
            b_msb_r <= b[WIDTH-1];
            bor_r   <= 1'b0;
            cnt_r   <= {CNT_W{1'b0}};
            busy_r  <= 1'b1;
            state_r <= ST_SHIFT;
          end else begin
            busy_r  <= 1'b0;
          end
        end
        ST_SHIFT: begin
          sa_r  <= {1'b0, sa_r[WIDTH-1:1]};
          sb_r  <= {1'b0, sb_r[WIDTH-1:1]};
          sr_r  <= sr_next_s;
          bor_r <= bo_s;
          cnt_r <= cnt_r + CNT_ONE;
          // Outputs load on the edge that enters DONE so diff and done align.
          if (cnt_r == CNT_LAST) begin
            diff_r   <= sr_next_s;
            borrow_r <= bo_s;
            ovf_r    <= (a_msb_r != b_msb_r) && (d_s != a_msb_r);
            done_r   <= 1'b1;
            state_r  <= ST_DONE;
          end
        end
        ST_DONE: begin
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy       = busy_r;
  assign done       = done_r;
  assign diff       = diff_r;
  assign borrow_out = borrow_r;
  assign ovf        = ovf_r;

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Scoreboard bench for serial_sub_ctrl: directed plan cases plus random ops.
module tb_serial_sub_ctrl;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic             op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow_out;
  logic             ovf;

  typedef struct packed {
    logic [WIDTH-1:0] diff;
    logic             borrow;
    logic             ovf;
  } exp_t;

  exp_t exp_q[$];
  int   errors    = 0;
  int   checks    = 0;
  int   done_seen = 0;

  serial_sub_ctrl #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .op         (op),
    .a          (a),
    .b          (b),
    .busy       (busy),
    .done       (done),
    .diff       (diff),
    .borrow_out (borrow_out),
    .ovf        (ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int unsigned act, input int unsigned req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Reference: plain integer arithmetic on the effective operands.
  function automatic exp_t model(input logic o, input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv);
    exp_t e;
    int ai, bi, si, sb, sd, full;
    full = 1 << WIDTH;
    ai = (o == 1'b1) ? 0 : int'(av);
    bi = int'(bv);
    si = (ai >= full / 2) ? ai - full : ai;
    sb = (bi >= full / 2) ? bi - full : bi;
    sd = si - sb;
    e.diff   = WIDTH'((ai - bi + full) % full);
    e.borrow = (ai < bi);
    e.ovf    = (sd > full / 2 - 1) || (sd < -(full / 2));
    return e;
  endfunction

  // Monitor: every done pulse pops one expected result.
  always @(negedge clk) begin
    if (!reset && done === 1'b1) begin
      done_seen++;
      if (exp_q.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("diff", diff, e.diff);
        check("borrow_out", borrow_out, e.borrow);
        check("ovf", ovf, e.ovf);
      end
    end
  end

  // Called at a negedge with the DUT idle; returns at the negedge after done.
  task automatic run_op(input logic o, input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                        input bit inject);
    int n0, cyc, done_at;
    n0 = done_seen;
    done_at = -1;
    op = o; a = av; b = bv; start = 1'b1;
    exp_q.push_back(model(o, av, bv));
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (busy === 1'b1 && cyc < 40) begin
      if (done === 1'b1) done_at = cyc;
      if (inject && (cyc == 2 || cyc == WIDTH)) begin
        start = 1'b1; op = 1'($urandom); a = WIDTH'($urandom); b = WIDTH'($urandom);
      end else begin
        start = 1'b0; op = 1'($urandom); a = WIDTH'($urandom); b = WIDTH'($urandom);
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    check("busy_cycles", cyc, WIDTH + 1);
    check("done_cycle", done_at, WIDTH);
    check("done_count", done_seen - n0, 1);
  endtask

  initial begin
    int n0;
    reset = 1'b1; start = 1'b0; op = 1'b0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_diff", diff, 0);
    check("rst_borrow", borrow_out, 0);
    check("rst_ovf", ovf, 0);
    reset = 1'b0;

    run_op(1'b0, 8'h05, 8'h03, 1'b0);
    run_op(1'b0, 8'h03, 8'h05, 1'b0);
    run_op(1'b0, 8'h80, 8'h01, 1'b0);
    run_op(1'b0, 8'h7F, 8'hFF, 1'b0);
    run_op(1'b1, 8'hAA, 8'h01, 1'b0);
    run_op(1'b1, 8'hAA, 8'h00, 1'b0);
    run_op(1'b1, 8'hAA, 8'h80, 1'b0);
    run_op(1'b0, 8'h10, 8'h01, 1'b1);
    run_op(1'b0, 8'h20, 8'h01, 1'b0);

    // Abort in SHIFT cycle 4.
    op = 1'b0; a = 8'h33; b = 8'h11; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    n0 = done_seen;
    @(negedge clk);
    reset = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_diff", diff, 0);
    check("abort_borrow", borrow_out, 0);
    check("abort_ovf", ovf, 0);
    repeat (WIDTH + 3) @(negedge clk);
    check("abort_no_done", done_seen - n0, 0);

    // Reset and start together: start must be dropped.
    reset = 1'b1; start = 1'b1; op = 1'b0; a = 8'h05; b = 8'h03;
    @(negedge clk);
    reset = 1'b0; start = 1'b0;
    @(negedge clk);
    check("rst_start_busy", busy, 0);

    run_op(1'b0, 8'h09, 8'h04, 1'b0);

    for (int i = 0; i < 40; i++) begin
      run_op(1'($urandom), WIDTH'($urandom), WIDTH'($urandom), 1'($urandom));
    end

    repeat (2) @(negedge clk);
    check("queue_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
